// File: rtl/spi_slave_transmitter.sv
`timescale 1ns/1ps
// spi_slave_transmitter
//
// SPI slave-side transmitter (MISO path). Local logic queues words in a
// small TX FIFO. Each word is shifted out MSB first in SPI mode 0 while the
// master holds slave select low. SCLK_IN and SS_IN are asynchronous pins,
// so they are synchronised into master_clock before edge detection.
//
// Ports
//   master_clock    : system clock; all logic updates on its rising edge
//   do_reset        : synchronous, active-high reset
//   is_ready        : 0 while in reset, 1 from the first cycle after it drops
//   SCLK_IN, SS_IN  : SPI clock and active-low slave select from the master
//   OUTPUT_SIGNAL   : MISO data
//   OUTPUT_ENABLE   : MISO driver enable, high only while shifting
//   data_word_send  : word to queue
//   send_valid      : push request
//   send_ready      : FIFO not full
//   fifo_level      : number of queued words
//   processing_word : high while shifting
//   word_done       : one-cycle pulse after a complete word has been sent
//   underrun        : one-cycle pulse when IDLE_WORD was loaded from an empty FIFO
//   frame_abort     : one-cycle pulse when SS was released mid-word
module spi_slave_transmitter #(
  parameter int                  WORD_LEN    = 8,
  parameter int                  FIFO_DEPTH  = 4,
  parameter int                  SYNC_STAGES = 2,
  parameter logic [WORD_LEN-1:0] IDLE_WORD   = '0
) (
  input  logic                          master_clock,
  input  logic                          do_reset,
  output logic                          is_ready,
  input  logic                          SCLK_IN,
  input  logic                          SS_IN,
  output logic                          OUTPUT_SIGNAL,
  output logic                          OUTPUT_ENABLE,
  input  logic [WORD_LEN-1:0]           data_word_send,
  input  logic                          send_valid,
  output logic                          send_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          processing_word,
  output logic                          word_done,
  output logic                          underrun,
  output logic                          frame_abort
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(WORD_LEN + 1);

  localparam logic [CNT_W-1:0] WORD_CNT = CNT_W'(WORD_LEN);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  // Synchroniser chains, edge-detect flops and a validity chain. The
  // validity chain marks when the edge-detect flop holds a real pin sample
  // rather than a reset value, so a pin already low at reset release does
  // not look like a falling edge.
  logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic                   ss_prev_q, ss_prev_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic [SYNC_STAGES:0]   sync_valid_q, sync_valid_d;

  logic ss_fall, ss_rise, sclk_rise, sclk_fall;

  // Control state
  logic [0:0]          state_q, state_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WORD_LEN-1:0] shift_q, shift_d;

  // FIFO
  logic [WORD_LEN-1:0] mem_q [FIFO_DEPTH];
  logic [WORD_LEN-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0]    level_q, level_d;

  // Registered outputs
  logic is_ready_q, is_ready_d;
  logic miso_q, miso_d;
  logic oe_q, oe_d;
  logic word_done_q, word_done_d;
  logic underrun_q, underrun_d;
  logic frame_abort_q, frame_abort_d;

  logic load, push, pop, ready_int;

  always_comb begin
    ss_sync_d    = {ss_sync_q[SYNC_STAGES-2:0], SS_IN};
    sclk_sync_d  = {sclk_sync_q[SYNC_STAGES-2:0], SCLK_IN};
    ss_prev_d    = ss_sync_q[SYNC_STAGES-1];
    sclk_prev_d  = sclk_sync_q[SYNC_STAGES-1];
    sync_valid_d = {sync_valid_q[SYNC_STAGES-1:0], 1'b1};
  end

  always_comb begin
    ss_fall   = sync_valid_q[SYNC_STAGES] &  ss_prev_q   & ~ss_sync_q[SYNC_STAGES-1];
    ss_rise   = sync_valid_q[SYNC_STAGES] & ~ss_prev_q   &  ss_sync_q[SYNC_STAGES-1];
    sclk_rise = sync_valid_q[SYNC_STAGES] & ~sclk_prev_q &  sclk_sync_q[SYNC_STAGES-1];
    sclk_fall = sync_valid_q[SYNC_STAGES] &  sclk_prev_q & ~sclk_sync_q[SYNC_STAGES-1];
  end

  // Word sequencing. ss_rise outranks any SCLK strobe in the same cycle, so a
  // master that releases SS together with the last SCLK fall completes the
  // word without triggering another load.
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    load          = 1'b0;
    word_done_d   = 1'b0;
    underrun_d    = 1'b0;
    frame_abort_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ss_fall) begin
          load      = 1'b1;
          bit_cnt_d = '0;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (ss_rise) begin
          state_d   = ST_IDLE;
          bit_cnt_d = '0;
          if (bit_cnt_q == WORD_CNT) begin
            word_done_d = 1'b1;
          end else if (bit_cnt_q != '0) begin
            frame_abort_d = 1'b1;
          end
        end else if (sclk_rise) begin
          if (bit_cnt_q != WORD_CNT) begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end else if (sclk_fall) begin
          if (bit_cnt_q == WORD_CNT) begin
            word_done_d = 1'b1;
            load        = 1'b1;
            bit_cnt_d   = '0;
          end else if (bit_cnt_q != '0) begin
            shift_d = {shift_q[WORD_LEN-2:0], 1'b0};
          end
        end
      end
      default: begin
        state_d   = ST_IDLE;
        bit_cnt_d = '0;
      end
    endcase

    // A load looks only at the level before this cycle's push, so a word
    // pushed into an empty FIFO during a load stays queued.
    pop = load && (level_q != '0);
    if (load) begin
      if (level_q != '0) begin
        shift_d = mem_q[rd_ptr_q];
      end else begin
        shift_d    = IDLE_WORD;
        underrun_d = 1'b1;
      end
    end
  end

  // FIFO bookkeeping. Fullness is judged on the registered level, so a push
  // while full is dropped even when a pop happens in the same cycle.
  always_comb begin
    ready_int = is_ready_q && (level_q < FULL_LVL);
    push      = send_valid && ready_int;
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    if (push) begin
      mem_d[wr_ptr_q] = data_word_send;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Pin-facing outputs are registered from the current state, which puts
  // one more flop between a pin edge and its visible effect.
  always_comb begin
    is_ready_d = 1'b1;
    oe_d       = (state_q == ST_SHIFT);
    miso_d     = (state_q == ST_SHIFT) && shift_q[WORD_LEN-1];
  end

  always_ff @(posedge master_clock) begin
    if (do_reset) begin
      ss_sync_q     <= '1;
      sclk_sync_q   <= '0;
      ss_prev_q     <= 1'b1;
      sclk_prev_q   <= 1'b0;
      sync_valid_q  <= '0;
      state_q       <= ST_IDLE;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      level_q       <= '0;
      is_ready_q    <= 1'b0;
      miso_q        <= 1'b0;
      oe_q          <= 1'b0;
      word_done_q   <= 1'b0;
      underrun_q    <= 1'b0;
      frame_abort_q <= 1'b0;
    end else begin
      ss_sync_q     <= ss_sync_d;
      sclk_sync_q   <= sclk_sync_d;
      ss_prev_q     <= ss_prev_d;
      sclk_prev_q   <= sclk_prev_d;
      sync_valid_q  <= sync_valid_d;
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      level_q       <= level_d;
      is_ready_q    <= is_ready_d;
      miso_q        <= miso_d;
      oe_q          <= oe_d;
      word_done_q   <= word_done_d;
      underrun_q    <= underrun_d;
      frame_abort_q <= frame_abort_d;
    end
  end

  // Storage needs no reset; the pointers and level define what is valid.
  always_ff @(posedge master_clock) begin
    mem_q <= mem_d;
  end

  assign is_ready        = is_ready_q;
  assign OUTPUT_SIGNAL   = miso_q;
  assign OUTPUT_ENABLE   = oe_q;
  assign processing_word = oe_q;
  assign send_ready      = ready_int;
  assign fifo_level      = level_q;
  assign word_done       = word_done_q;
  assign underrun        = underrun_q;
  assign frame_abort     = frame_abort_q;

endmodule
